// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the 2-input gate sweep controller.
package gate_sweep_pkg;

    localparam int NUM_VEC = 4;
    localparam int IDX_W   = $clog2(NUM_VEC);
    localparam int CNT_W   = 4;
    localparam int ERR_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Handshake and gate-stimulus bundle between the sweep controller and its user/DUT side.
interface gate_sweep_ctrl_if;
    import gate_sweep_pkg::*;

    logic               start;
    logic               y;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [NUM_VEC-1:0] err_vec;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, err_vec
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, err_vec
    );

endinterface

// File: rtl/sweep_settle_timer.sv
// Load/decrement settle counter; zero flags the decrement that brings the count to 0.
module sweep_settle_timer
    import gate_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Flag the last wait cycle so the FSM leaves WAIT after exactly load_val cycles.
    assign zero = dec && (cnt == CNT_W'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Clocked self-checking sweep of a 2-input gate against a truth table.
// Optional GATE_SWEEP_ERRVEC_EN: keep a per-vector mismatch register on err_vec.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                 SETTLE = 2,
    parameter logic [NUM_VEC-1:0] TRUTH  = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_sweep_ctrl_if.slave  bus
);

    if (SETTLE < 1 || SETTLE > (2**CNT_W) - 1) begin : g_settle_range
        $error("gate_sweep_ctrl: SETTLE must be in 1..15");
    end

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [1:0]         ab;
    logic [1:0]         ab_nxt;
    logic               busy_r;
    logic               busy_nxt;
    logic               done_r;
    logic               done_nxt;
    logic               pass_r;
    logic               pass_nxt;
    logic [ERR_W-1:0]   err_cnt_r;
    logic               accept;
    logic               miss;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;

    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (CNT_W'(SETTLE)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ab_nxt    = ab;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        pass_nxt  = pass_r;
        accept    = 1'b0;
        miss      = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    idx_nxt   = '0;
                    pass_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                ab_nxt    = idx;
                tmr_load  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                miss = (bus.y != TRUTH[idx]);
                if (idx == IDX_W'(NUM_VEC - 1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = APPLY;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                pass_nxt  = (err_cnt_r == '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // At most NUM_VEC misses per sweep, so err_cnt never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            ab        <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            idx    <= idx_nxt;
            ab     <= ab_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            pass_r <= pass_nxt;
            if (accept) begin
                err_cnt_r <= '0;
            end else if (miss) begin
                err_cnt_r <= err_cnt_r + 1'b1;
            end
        end
    end

`ifdef GATE_SWEEP_ERRVEC_EN
    logic [NUM_VEC-1:0] err_vec_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_vec_r <= '0;
        end else if (accept) begin
            err_vec_r <= '0;
        end else if (miss) begin
            err_vec_r[idx] <= 1'b1;
        end
    end

    assign bus.err_vec = err_vec_r;
`else
    assign bus.err_vec = '0;
`endif

    assign bus.a       = ab[1];
    assign bus.b       = ab[0];
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.err_cnt = err_cnt_r;

endmodule
